// File: rtl/execute_stage_if.sv
// Bundle of signals between the Y86-64 Execute stage and its surroundings:
// the E register, the CC register, the hazard unit and the M register outputs.
interface execute_stage_if #(
    parameter int WORD = 64
);
    logic [2:0]      E_stat;
    logic [3:0]      E_icode;
    logic [3:0]      E_ifun;
    logic [WORD-1:0] E_valA;
    logic [WORD-1:0] E_valB;
    logic [WORD-1:0] E_valC;
    logic [3:0]      E_dstE;
    logic [3:0]      E_dstM;
    logic [2:0]      m_stat;
    logic [2:0]      W_stat;
    logic            M_stall;
    logic            M_bubble;
    logic [2:0]      cc_q;

    logic [2:0]      cc_d;
    logic            cc_set;
    logic            e_Cnd;
    logic [WORD-1:0] e_valE;
    logic [3:0]      e_dstE;

    logic [2:0]      M_stat;
    logic [3:0]      M_icode;
    logic            M_Cnd;
    logic [WORD-1:0] M_valE;
    logic [WORD-1:0] M_valA;
    logic [3:0]      M_dstE;
    logic [3:0]      M_dstM;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output m_stat, W_stat, M_stall, M_bubble, cc_q,
        input  cc_d, cc_set, e_Cnd, e_valE, e_dstE,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  m_stat, W_stat, M_stall, M_bubble, cc_q,
        output cc_d, cc_set, e_Cnd, e_valE, e_dstE,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: ALU operand/function select, flag generation,
// branch/cmov condition evaluation and the E->M pipeline register.
module execute_stage #(
    parameter int WORD = 64
) (
    input  logic          clk,
    input  logic          async_reset,
    execute_stage_if.slave ex
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]      stat;
        logic [3:0]      icode;
        logic            cnd;
        logic [WORD-1:0] val_e;
        logic [WORD-1:0] val_a;
        logic [3:0]      dst_e;
        logic [3:0]      dst_m;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        stat: S_AOK, icode: I_NOP, cnd: 1'b0,
        val_e: '0, val_a: '0, dst_e: RNONE, dst_m: RNONE
    };

    logic [WORD-1:0] alu_a;
    logic [WORD-1:0] alu_b;
    logic [3:0]      alu_fun;
    logic [WORD-1:0] alu_r;
    logic            alu_of;
    logic            cnd;
    logic            zf, sf, of;
    m_reg_t          m_d, m_q;

    always_comb begin
        alu_a = '0;
        unique case (ex.E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = ex.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex.E_valC;
            I_CALL, I_PUSHQ:              alu_a = -WORD'(8);
            I_RET, I_POPQ:                alu_a = WORD'(8);
            default:                      alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        unique case (ex.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_PUSHQ, I_RET, I_POPQ:       alu_b = ex.E_valB;
            default:                      alu_b = '0;
        endcase
    end

    assign alu_fun = (ex.E_icode == I_OPQ) ? ex.E_ifun : A_ADD;

    // Overflow is judged on operand/result signs; unknown functions fall back to ADD.
    always_comb begin
        alu_r  = alu_b + alu_a;
        alu_of = (alu_a[WORD-1] == alu_b[WORD-1]) && (alu_r[WORD-1] != alu_a[WORD-1]);
        unique case (alu_fun)
            A_SUB: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_b[WORD-1] != alu_a[WORD-1]) && (alu_r[WORD-1] != alu_b[WORD-1]);
            end
            A_AND: begin
                alu_r  = alu_b & alu_a;
                alu_of = 1'b0;
            end
            A_XOR: begin
                alu_r  = alu_b ^ alu_a;
                alu_of = 1'b0;
            end
            default: ;
        endcase
    end

    assign ex.e_valE = alu_r;
    assign ex.cc_d   = {(alu_r == '0), alu_r[WORD-1], alu_of};

    // Flags are not committed while an exception is draining further down the pipe.
    assign ex.cc_set = (ex.E_icode == I_OPQ)
                    && !(ex.m_stat inside {S_ADR, S_INS, S_HLT})
                    && !(ex.W_stat inside {S_ADR, S_INS, S_HLT});

    assign {zf, sf, of} = ex.cc_q;

    always_comb begin
        cnd = 1'b0;
        unique case (ex.E_ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (sf ^ of) | zf;
            4'h2:    cnd = sf ^ of;
            4'h3:    cnd = zf;
            4'h4:    cnd = ~zf;
            4'h5:    cnd = ~(sf ^ of);
            4'h6:    cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end

    assign ex.e_Cnd  = cnd;
    assign ex.e_dstE = (ex.E_icode == I_RRMOVQ && !cnd) ? RNONE : ex.E_dstE;

    always_comb begin
        m_d = m_q;
        if (ex.M_bubble) begin
            m_d = M_BUBBLE;
        end else if (!ex.M_stall) begin
            m_d.stat  = ex.E_stat;
            m_d.icode = ex.E_icode;
            m_d.cnd   = cnd;
            m_d.val_e = alu_r;
            m_d.val_a = ex.E_valA;
            m_d.dst_e = ex.e_dstE;
            m_d.dst_m = ex.E_dstM;
        end
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            m_q <= M_BUBBLE;
        end else begin
            m_q <= m_d;
        end
    end

    assign ex.M_stat  = m_q.stat;
    assign ex.M_icode = m_q.icode;
    assign ex.M_Cnd   = m_q.cnd;
    assign ex.M_valE  = m_q.val_e;
    assign ex.M_valA  = m_q.val_a;
    assign ex.M_dstE  = m_q.dst_e;
    assign ex.M_dstM  = m_q.dst_m;
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipelined Execute stage, sitting between the E pipeline register and the memory stage.
- It consumes the 3-bit condition-code register's output to evaluate jump and cmov conditions.
- It drives that register's `in` and `set` inputs with freshly generated flags.
- It contains the ALU operand/function selection and flag generation, plus the E→M pipeline register with stall/bubble control.

Parameters:
WORD, 64, datapath width in bits (valA/valB/valC/valE)

Ports:
clk  input  1  system clock, rising-edge
async_reset  input  1  asynchronous reset, active-low (0 = reset)
E_stat  input  3  instruction status (AOK=1, HLT=2, ADR=3, INS=4)
E_icode  input  4  instruction code (HALT0 NOP1 RRMOVQ2 IRMOVQ3 RMMOVQ4 MRMOVQ5 OPQ6 JXX7 CALL8 RET9 PUSHQ A POPQ B)
E_ifun  input  4  function code (ALU: ADD0 SUB1 AND2 XOR3; cond: ALW0 LE1 L2 E3 NE4 GE5 G6)
E_valA, E_valB, E_valC  input  WORD each  operands
E_dstE, E_dstM  input  4 each  destination registers (RNONE=4'hF)
m_stat  input  3  status of the instruction currently in Memory
W_stat  input  3  status of the instruction currently in Writeback
M_stall  input  1  hold M register
M_bubble  input  1  load NOP bubble into M register
cc_q  input  3  current CC register value {ZF,SF,OF}
cc_d  output  3  new flags {ZF,SF,OF} to CC register
cc_set  output  1  CC load enable
e_Cnd  output  1  condition result (combinational)
e_valE  output  WORD  ALU result (combinational, forwarding path)
e_dstE  output  4  effective dstE (combinational, forwarding path)
M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  output  3/4/1/WORD/WORD/4/4  registered M stage

Behaviour:
- aluA:
  - E_valA for RRMOVQ and OPQ.
  - E_valC for IRMOVQ, RMMOVQ, MRMOVQ.
  - −8 for CALL and PUSHQ.
  - +8 for RET and POPQ.
  - 0 otherwise.
- aluB:
  - E_valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ.
  - 0 otherwise.
- alufun = E_ifun when icode=OPQ, else ADD. Unknown OPQ ifun (>3) computes ADD.
- e_valE = aluB op aluA:
  - SUB is aluB − aluA.
  - Arithmetic is modulo 2^WORD; carry is discarded.
- Flags:
  - ZF = (e_valE==0); SF = e_valE[WORD−1].
  - OF for ADD = (a_sign==b_sign) && (r_sign!=a_sign).
  - OF for SUB = (b_sign!=a_sign) && (r_sign!=b_sign).
  - OF=0 for AND and XOR.
  - cc_d = {ZF,SF,OF}.
- cc_set = (E_icode==OPQ) && m_stat∉{ADR,INS,HLT} && W_stat∉{ADR,INS,HLT}.
  - The CC register therefore updates on the same edge that OPQ leaves E.
  - A JXX/CMOV immediately following sees the updated flags one cycle later, via cc_q.
- e_Cnd is evaluated from cc_q with E_ifun:
  - ALW=1; LE=(SF^OF)|ZF; L=SF^OF; E=ZF; NE=~ZF; GE=~(SF^OF); G=~(SF^OF)&~ZF.
  - ifun>6 gives 0.
- e_dstE = RNONE when E_icode==RRMOVQ && !e_Cnd (failed cmov), else E_dstE.
- M register, at the rising clk edge:
  - async_reset=0 (immediately, asynchronously): M_stat=AOK, M_icode=NOP, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
  - Else if M_bubble: load those same bubble values.
  - Else if M_stall: hold all fields.
  - Else load {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
  - Bubble has priority over stall.
- Latency: combinational outputs are valid in the same cycle; M fields become visible one cycle after E presents the instruction.
- Reset mid-operation: the M register clears without waiting for clk. cc_set and cc_d stay purely combinational; the CC register clears itself.
- Stalled M with an OPQ in E: cc_set still follows the rule above. Upstream control must also stall E.

Test Plan:
- Reset: async_reset pulsed 0 between edges → all M_* take bubble values immediately; M_icode=1, M_dstE=4'hF.
- OPQ SUB: valB=5, valA=7, m_stat=W_stat=AOK → e_valE=0xFFFF_FFFF_FFFF_FFFE, cc_d=3'b010, cc_set=1. Next edge M_valE equals the same value.
- ADD overflow: valA=valB=0x7FFF_FFFF_FFFF_FFFF → e_valE=0xFFFF_FFFF_FFFF_FFFE, cc_d=3'b011. With W_stat=ADR → cc_set=0.
- Failed cmov: E_icode=2, ifun=3 (cmove), cc_q=3'b000, E_dstE=3 → e_Cnd=0, e_dstE=4'hF. With cc_q=3'b100 → e_Cnd=1, e_dstE=3.
- Jumps over all ifun 0–6 × all 8 cc_q values → e_Cnd matches the table; ifun=7 → 0.
- Pipeline control: with E_icode=8 (CALL), E_valB=0x100 → e_valE=0xF8.
  - M_stall=1 holds the previous M contents.
  - M_bubble=1 together with M_stall=1 loads the bubble.
  - With neither asserted → M_icode=8, M_valE=0xF8.
